// File: rtl/net_argmax_stage_pkg.sv
// Shared definitions for the classifier argmax stage: element type,
// most-negative element constant and the index-width helper.
package net_pkg;

  // Default geometry of the upstream network's final layer.
  localparam int NET_T = 16;
  localparam int NET_M = 12;

  // One signed network output element.
  typedef logic signed [NET_T-1:0] elem_t;

  // Most-negative element value: sign bit set, all other bits clear.
  localparam elem_t ELEM_MIN = {1'b1, {(NET_T-1){1'b0}}};

  // Width of an index that addresses positions 0..m-1 (m >= 2).
  function automatic int idxw(input int m);
    int w;
    w = 1;
    while ((32'sd1 << w) < m) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/net_argmax_stage_cmp.sv
// Combinational signed compare/select for the running argmax.
// The first element of a vector is taken unconditionally; any later
// element replaces the running best only when strictly greater, so a tie
// keeps the lower index.
module net_argmax_cmp
  import net_pkg::*;
#(
  parameter int T    = NET_T,
  parameter int IDXW = idxw(NET_M)
) (
  input  logic signed [T-1:0]    i_best,
  input  logic [IDXW-1:0]        i_bestidx,
  input  logic signed [T-1:0]    i_data,
  input  logic [IDXW-1:0]        i_cnt,
  input  logic                   i_first,
  output logic signed [T-1:0]    o_best,
  output logic [IDXW-1:0]        o_idx
);

  logic w_greater;

  // Strict signed comparison of the incoming element against the running best.
  always_comb begin
    w_greater = 1'b0;
    if (i_data > i_best) begin
      w_greater = 1'b1;
    end else begin
      w_greater = 1'b0;
    end
  end

  // Select the next best value and its position.
  always_comb begin
    o_best = i_best;
    o_idx  = i_bestidx;
    if (i_first) begin
      o_best = i_data;
      o_idx  = {IDXW{1'b0}};
    end else if (w_greater) begin
      o_best = i_data;
      o_idx  = i_cnt;
    end else begin
      o_best = i_best;
      o_idx  = i_bestidx;
    end
  end

endmodule

// File: rtl/net_argmax_stage.sv
// Argmax stage placed after the fully-connected network: groups M
// consecutive signed elements into a vector and emits (index, value) of
// the largest one. Results are registered; only input_ready is
// combinational, and it depends on state and output_ready alone.
module net_argmax_stage
  import net_pkg::*;
#(
  parameter int  T    = NET_T,
  parameter int  M    = NET_M,
  localparam int IDXW = idxw(M)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                input_valid,
  output logic                input_ready,
  input  logic signed [T-1:0] input_data,
  output logic                output_valid,
  input  logic                output_ready,
  output logic [IDXW-1:0]     output_index,
  output logic signed [T-1:0] output_max
);

  localparam logic signed [T-1:0] L_MIN  = {1'b1, {(T-1){1'b0}}};
  localparam logic [IDXW-1:0]     L_LAST = IDXW'(M - 1);

  // Running state of the vector currently being collected.
  logic [IDXW-1:0]     r_cnt;
  logic signed [T-1:0] r_best;
  logic [IDXW-1:0]     r_bestidx;

  // Result holding register.
  logic                r_out_valid;
  logic [IDXW-1:0]     r_out_idx;
  logic signed [T-1:0] r_out_max;

  logic                w_first;
  logic                w_last;
  logic                w_ready;
  logic                w_acc;
  logic                w_out_take;
  logic signed [T-1:0] w_next_best;
  logic [IDXW-1:0]     w_next_idx;

  // Decode vector position and both handshakes. Only the completing
  // element stalls, and only while a result is still unconsumed.
  always_comb begin
    w_first    = (r_cnt == {IDXW{1'b0}});
    w_last     = (r_cnt == L_LAST);
    w_ready    = 1'b1;
    if (w_last && r_out_valid && !output_ready) begin
      w_ready = 1'b0;
    end else begin
      w_ready = 1'b1;
    end
    w_acc      = input_valid && w_ready;
    w_out_take = r_out_valid && output_ready;
  end

  // Shared compare feeds both the running best and the final result.
  net_argmax_cmp #(
    .T    (T),
    .IDXW (IDXW)
  ) u_cmp (
    .i_best    (r_best),
    .i_bestidx (r_bestidx),
    .i_data    (input_data),
    .i_cnt     (r_cnt),
    .i_first   (w_first),
    .o_best    (w_next_best),
    .o_idx     (w_next_idx)
  );

  // Element counter and running best; a partial vector is lost on reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt     <= {IDXW{1'b0}};
      r_best    <= L_MIN;
      r_bestidx <= {IDXW{1'b0}};
    end else if (w_acc) begin
      r_best    <= w_next_best;
      r_bestidx <= w_next_idx;
      if (w_last) begin
        r_cnt <= {IDXW{1'b0}};
      end else begin
        r_cnt <= r_cnt + IDXW'(1);
      end
    end else begin
      r_cnt     <= r_cnt;
      r_best    <= r_best;
      r_bestidx <= r_bestidx;
    end
  end

  // Result register: a completion loads a new result (even in the same
  // cycle the previous one is taken); otherwise a take clears valid.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_out_valid <= 1'b0;
      r_out_idx   <= {IDXW{1'b0}};
      r_out_max   <= {T{1'b0}};
    end else if (w_acc && w_last) begin
      r_out_valid <= 1'b1;
      r_out_idx   <= w_next_idx;
      r_out_max   <= w_next_best;
    end else if (w_out_take) begin
      r_out_valid <= 1'b0;
      r_out_idx   <= r_out_idx;
      r_out_max   <= r_out_max;
    end else begin
      r_out_valid <= r_out_valid;
      r_out_idx   <= r_out_idx;
      r_out_max   <= r_out_max;
    end
  end

  assign input_ready  = w_ready;
  assign output_valid = r_out_valid;
  assign output_index = r_out_idx;
  assign output_max   = r_out_max;

endmodule

// File: doc/net_argmax_stage.md
Name: net_argmax_stage

Overview:
- Downstream consumer of the fully-connected network output stream. Placed directly after net_4_8_12_16_16_1_20 in the classifier datapath.
- Groups consecutive signed T-bit network outputs into vectors of M elements.
- For each vector, emits the index and value of the largest element as one result word.
- Valid/ready handshake on both sides, same semantics as the network interfaces.

Parameters:
- T, 16, element width in bits (signed two's complement).
- M, 12, elements per vector; equals the final layer size of the upstream network; M >= 2.
- IDXW, $clog2(M), width of the index output; derived, not overridden.

Ports:
- clk  in  1  system clock; all state on the rising edge.
- reset  in  1  asynchronous, active-low reset; asserted when 0, clears all state immediately.
- input_valid  in  1  upstream element valid (driven by network output_valid).
- input_ready  out  1  element accepted when input_valid && input_ready at the rising edge.
- input_data  in  T  signed element (network output_data).
- output_valid  out  1  result word valid.
- output_ready  in  1  downstream accepts the result when output_valid && output_ready at the rising edge.
- output_index  out  IDXW  position (0..M-1) of the maximum element within the vector.
- output_max  out  T  signed value of that maximum element.

Behaviour:
- Registers:
  - cnt[IDXW-1:0]: element position in the current vector.
  - best: signed T.
  - bestidx: IDXW.
  - result registers: output_index, output_max.
  - output_valid flag.
- Reset (reset==0, asynchronous):
  - cnt=0, best=most-negative (1 followed by T-1 zeros), bestidx=0.
  - output_valid=0, output_index=0, output_max=0.
  - A partial vector is discarded.
  - The first accepted element after reset release is element 0.
- Accept (acc = input_valid && input_ready):
  - Element at cnt=0: best<=input_data, bestidx<=0 unconditionally.
  - Element at cnt>0: replace best/bestidx only if input_data > best (signed, strict).
  - Ties therefore keep the lowest index.
  - cnt increments on each accept and wraps M-1 -> 0.
- Vector completion, i.e. accepting the element at cnt==M-1:
  - Compute the final compare including this element.
  - Load output_index/output_max with the result; output_valid<=1.
  - cnt<=0.
  - Latency: result valid in the cycle after the last element is accepted.
- input_ready = !(cnt==M-1 && output_valid && !output_ready), combinational:
  - Elements 0..M-2 of the next vector are always accepted, even while a result is held.
  - Only the completing element stalls while an unconsumed result is pending.
- Output handshake:
  - On output_valid && output_ready with no simultaneous completion: output_valid<=0.
  - With a simultaneous completion: output_valid stays 1 and the new result is loaded.
  - No bubble; full throughput is one vector per M cycles.
- Hold stability:
  - While output_valid && !output_ready, output_index/output_max are stable.
  - output_valid does not drop.
- input_data is ignored (may be X) when input_valid==0.
- No combinational path from input_data to outputs.

Decomposition:
- Shared package net_pkg:
  - element typedef elem_t = logic signed [T-1:0];
  - most-negative constant ELEM_MIN;
  - index-width function idxw(M).
- One natural sub-module: net_argmax_cmp.
  - Combinational signed compare/select.
  - Inputs: best, bestidx, input_data, cnt, first flag.
  - Outputs: next best and next index.
  - Reused for the completion path.

Test Plan:
- M=12, vector 0..11 = {5,-3,7,2,7,0,1,1,1,1,1,1}, output_ready=1 -> output_index=2, output_max=7 (tie at index 4 ignored), output_valid one cycle after element 11.
- All elements 16'h8000 -> output_index=0, output_max=16'h8000 (most-negative initial value does not block element 0).
- Two back-to-back vectors, input_valid=1 every cycle, output_ready=1, maxima at index 11 (value 100) then index 0 (value -1, all others -2) -> results (11,100) then (0,-1) exactly 12 cycles apart, no stall cycles.
- output_ready=0 held for 30 cycles after the first result, while a second vector streams:
  - input_ready falls only when cnt==11;
  - the first result stays stable;
  - raising output_ready delivers the first result, then the second result the next cycle.
- Assert reset (0) mid-vector after 5 elements, release, then feed a full 12-element vector -> exactly one result, computed from the new 12 elements only; outputs read 0/0 with output_valid=0 during reset.
- Random rb/rb2-style throttling on input_valid and output_ready over 3000 vectors with a scoreboard against a software argmax -> zero mismatches.
